// File: rtl/prism_sp_rx_dispatch_if.sv
// GEM RX beat stream as seen by the dispatcher: one beat per cycle, no back-pressure.
interface prism_sp_rx_dispatch_if #(
  parameter int DATA_WIDTH = 32
);
  localparam int BW = $clog2(DATA_WIDTH / 8) + 1;

  logic                  in_valid;
  logic                  in_sof;
  logic                  in_last;
  logic                  in_err;
  logic [BW-1:0]         in_bytes;
  logic [DATA_WIDTH-1:0] in_data;
  logic [7:0]            in_hash;

  modport master (
    output in_valid, in_sof, in_last, in_err, in_bytes, in_data, in_hash
  );

  modport slave (
    input in_valid, in_sof, in_last, in_err, in_bytes, in_data, in_hash
  );
endinterface

// File: rtl/prism_sp_rx_dispatch.sv
// Steers whole GEM RX frames into one of NRXCORES data/meta FIFO pairs with
// admission control, truncation and saturating statistics.
module prism_sp_rx_dispatch #(
  parameter int NRXCORES        = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int FREE_WIDTH      = 12,
  parameter int MAX_FRAME_BEATS = 512
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic [1:0]                     mode,
  input  logic                           enable,
  input  logic                           counters_clear,
  prism_sp_rx_dispatch_if.slave          rx,
  input  logic [NRXCORES*FREE_WIDTH-1:0] data_free,
  input  logic [NRXCORES*FREE_WIDTH-1:0] meta_free,
  output logic [NRXCORES-1:0]            data_wr_en,
  output logic [DATA_WIDTH-1:0]          data_wr_data,
  output logic [NRXCORES-1:0]            meta_wr_en,
  output logic [31:0]                    meta_wr_data,
  output logic [31:0]                    frame_count,
  output logic [31:0]                    drop_count,
  output logic [31:0]                    trunc_count
);
  localparam int BPB = DATA_WIDTH / 8;
  localparam int BW  = $clog2(BPB) + 1;
  localparam int TW  = (NRXCORES > 1) ? $clog2(NRXCORES) : 1;
  localparam int BCW = $clog2(MAX_FRAME_BEATS + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FORWARD = 2'd1,
    ST_DROP    = 2'd2
  } state_e;

  function automatic logic [NRXCORES-1:0] onehot(input logic [TW-1:0] idx);
    logic [NRXCORES-1:0] v;
    v = '0;
    for (int i = 0; i < NRXCORES; i++) begin
      v[i] = (idx == TW'(i));
    end
    return v;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [BW-1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] c, input logic inc);
    logic [31:0] r;
    if (inc && (c != 32'hFFFF_FFFF)) begin
      r = c + 32'd1;
    end else begin
      r = c;
    end
    return r;
  endfunction

  state_e                state_q, state_d;
  logic [TW-1:0]         rr_q, rr_d;
  logic [TW-1:0]         tgt_q, tgt_d;
  logic [BCW-1:0]        beat_cnt_q, beat_cnt_d;
  logic [15:0]           byte_len_q, byte_len_d;
  logic                  trunc_q, trunc_d;
  logic                  pend_v_q, pend_v_d;
  logic [TW-1:0]         pend_core_q, pend_core_d;
  logic [31:0]           pend_word_q, pend_word_d;
  logic [NRXCORES-1:0]   data_wr_en_q, data_wr_en_d;
  logic [DATA_WIDTH-1:0] data_wr_data_q, data_wr_data_d;
  logic [NRXCORES-1:0]   meta_wr_en_q, meta_wr_en_d;
  logic [31:0]           meta_wr_data_q, meta_wr_data_d;
  logic [31:0]           frame_count_q, frame_count_d;
  logic [31:0]           drop_count_q, drop_count_d;
  logic [31:0]           trunc_count_q, trunc_count_d;

  logic [TW-1:0]         best_idx_s, sel_tgt_s, rr_next_s;
  logic [FREE_WIDTH-1:0] best_free_s, sel_dfree_s, sel_mfree_s;
  logic                  admit_s, sof_s, keep_s;
  logic [BW-1:0]         last_bytes_s, beat_bytes_s;
  logic [15:0]           len_sum_s;
  logic                  close_v_s, new_v_s;
  logic [TW-1:0]         close_core_s, new_core_s;
  logic [31:0]           close_word_s, new_word_s;
  logic                  frame_inc_s, drop_inc_s, trunc_inc_s;

  assign sof_s = rx.in_valid & rx.in_sof;

  // Target selection (least-loaded, ties to lowest index) and admission check
  always_comb begin
    best_idx_s  = '0;
    best_free_s = data_free[0 +: FREE_WIDTH];
    for (int i = 1; i < NRXCORES; i++) begin
      if (data_free[i*FREE_WIDTH +: FREE_WIDTH] > best_free_s) begin
        best_free_s = data_free[i*FREE_WIDTH +: FREE_WIDTH];
        best_idx_s  = TW'(i);
      end else begin
        best_free_s = best_free_s;
      end
    end
    case (mode)
      2'd1:    sel_tgt_s = best_idx_s;
      2'd2:    sel_tgt_s = TW'(rx.in_hash & 8'(NRXCORES - 1));
      default: sel_tgt_s = rr_q;
    endcase
    sel_dfree_s = '0;
    sel_mfree_s = '0;
    for (int i = 0; i < NRXCORES; i++) begin
      if (sel_tgt_s == TW'(i)) begin
        sel_dfree_s = data_free[i*FREE_WIDTH +: FREE_WIDTH];
        sel_mfree_s = meta_free[i*FREE_WIDTH +: FREE_WIDTH];
      end else begin
        sel_dfree_s = sel_dfree_s;
      end
    end
    admit_s   = enable && (32'(sel_dfree_s) > 32'(MAX_FRAME_BEATS)) &&
                (sel_mfree_s > FREE_WIDTH'(1));
    rr_next_s = (rr_q == TW'(NRXCORES - 1)) ? TW'(0) : rr_q + TW'(1);
  end

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (sof_s) begin
      if (rx.in_last) begin
        state_d = ST_IDLE;
      end else begin
        state_d = admit_s ? ST_FORWARD : ST_DROP;
      end
    end else if (rx.in_valid && rx.in_last && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      state_d = state_q;
    end
  end

  // Frame datapath: data writes, meta candidates, counter increments
  always_comb begin
    rr_d           = rr_q;
    tgt_d          = tgt_q;
    beat_cnt_d     = beat_cnt_q;
    byte_len_d     = byte_len_q;
    trunc_d        = trunc_q;
    data_wr_en_d   = '0;
    data_wr_data_d = data_wr_data_q;
    close_v_s      = 1'b0;
    close_core_s   = tgt_q;
    close_word_s   = {2'b11, 14'd0, byte_len_q};
    new_v_s        = 1'b0;
    new_core_s     = tgt_q;
    new_word_s     = 32'd0;
    frame_inc_s    = 1'b0;
    drop_inc_s     = 1'b0;
    trunc_inc_s    = 1'b0;
    last_bytes_s   = (rx.in_bytes == '0) ? BW'(BPB) : rx.in_bytes;
    beat_bytes_s   = rx.in_last ? last_bytes_s : BW'(BPB);
    keep_s         = (beat_cnt_q < BCW'(MAX_FRAME_BEATS));
    len_sum_s      = sat_add16(byte_len_q, beat_bytes_s);
    if (sof_s) begin
      // A SOF while forwarding means the previous frame lost its last beat
      if (state_q == ST_FORWARD) begin
        close_v_s   = 1'b1;
        trunc_inc_s = 1'b1;
      end else begin
        close_v_s = 1'b0;
      end
      rr_d       = rr_next_s;
      beat_cnt_d = '0;
      byte_len_d = 16'd0;
      trunc_d    = 1'b0;
      if (admit_s) begin
        tgt_d          = sel_tgt_s;
        data_wr_en_d   = onehot(sel_tgt_s);
        data_wr_data_d = rx.in_data;
        if (rx.in_last) begin
          new_v_s     = 1'b1;
          new_core_s  = sel_tgt_s;
          new_word_s  = {rx.in_err, 1'b0, 14'd0, 16'(last_bytes_s)};
          frame_inc_s = 1'b1;
        end else begin
          beat_cnt_d = BCW'(1);
          byte_len_d = 16'(BPB);
        end
      end else begin
        drop_inc_s = 1'b1;
      end
    end else if (rx.in_valid && (state_q == ST_FORWARD)) begin
      if (keep_s) begin
        data_wr_en_d   = onehot(tgt_q);
        data_wr_data_d = rx.in_data;
        beat_cnt_d     = beat_cnt_q + BCW'(1);
      end else begin
        beat_cnt_d = beat_cnt_q;
      end
      if (rx.in_last) begin
        new_v_s     = 1'b1;
        new_core_s  = tgt_q;
        new_word_s  = {rx.in_err, trunc_q | ~keep_s, 14'd0, len_sum_s};
        frame_inc_s = 1'b1;
        trunc_inc_s = trunc_q | ~keep_s;
        beat_cnt_d  = '0;
        byte_len_d  = 16'd0;
        trunc_d     = 1'b0;
      end else begin
        byte_len_d = len_sum_s;
        trunc_d    = trunc_q | ~keep_s;
      end
    end else begin
      rr_d = rr_q;
    end
  end

  // Meta write arbitration; a close and a single-beat frame in one cycle leave one word pending
  always_comb begin
    meta_wr_en_d   = '0;
    meta_wr_data_d = meta_wr_data_q;
    pend_v_d       = 1'b0;
    pend_core_d    = pend_core_q;
    pend_word_d    = pend_word_q;
    if (pend_v_q) begin
      // A pending word implies IDLE last cycle, so no close can coincide with it
      meta_wr_en_d   = onehot(pend_core_q);
      meta_wr_data_d = pend_word_q;
      pend_v_d       = new_v_s;
      pend_core_d    = new_core_s;
      pend_word_d    = new_word_s;
    end else if (close_v_s && new_v_s) begin
      pend_v_d = 1'b1;
      if (close_core_s != new_core_s) begin
        meta_wr_en_d   = onehot(new_core_s);
        meta_wr_data_d = new_word_s;
        pend_core_d    = close_core_s;
        pend_word_d    = close_word_s;
      end else begin
        meta_wr_en_d   = onehot(close_core_s);
        meta_wr_data_d = close_word_s;
        pend_core_d    = new_core_s;
        pend_word_d    = new_word_s;
      end
    end else if (close_v_s) begin
      meta_wr_en_d   = onehot(close_core_s);
      meta_wr_data_d = close_word_s;
    end else if (new_v_s) begin
      meta_wr_en_d   = onehot(new_core_s);
      meta_wr_data_d = new_word_s;
    end else begin
      meta_wr_en_d = '0;
    end
  end

  // Statistics; a clear wins over a same-cycle increment
  always_comb begin
    if (counters_clear) begin
      frame_count_d = 32'd0;
      drop_count_d  = 32'd0;
      trunc_count_d = 32'd0;
    end else begin
      frame_count_d = sat_inc32(frame_count_q, frame_inc_s);
      drop_count_d  = sat_inc32(drop_count_q, drop_inc_s);
      trunc_count_d = sat_inc32(trunc_count_q, trunc_inc_s);
    end
  end

  // Datapath and output registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rr_q           <= '0;
      tgt_q          <= '0;
      beat_cnt_q     <= '0;
      byte_len_q     <= 16'd0;
      trunc_q        <= 1'b0;
      pend_v_q       <= 1'b0;
      pend_core_q    <= '0;
      pend_word_q    <= 32'd0;
      data_wr_en_q   <= '0;
      data_wr_data_q <= '0;
      meta_wr_en_q   <= '0;
      meta_wr_data_q <= 32'd0;
      frame_count_q  <= 32'd0;
      drop_count_q   <= 32'd0;
      trunc_count_q  <= 32'd0;
    end else begin
      rr_q           <= rr_d;
      tgt_q          <= tgt_d;
      beat_cnt_q     <= beat_cnt_d;
      byte_len_q     <= byte_len_d;
      trunc_q        <= trunc_d;
      pend_v_q       <= pend_v_d;
      pend_core_q    <= pend_core_d;
      pend_word_q    <= pend_word_d;
      data_wr_en_q   <= data_wr_en_d;
      data_wr_data_q <= data_wr_data_d;
      meta_wr_en_q   <= meta_wr_en_d;
      meta_wr_data_q <= meta_wr_data_d;
      frame_count_q  <= frame_count_d;
      drop_count_q   <= drop_count_d;
      trunc_count_q  <= trunc_count_d;
    end
  end

  assign data_wr_en   = data_wr_en_q;
  assign data_wr_data = data_wr_data_q;
  assign meta_wr_en   = meta_wr_en_q;
  assign meta_wr_data = meta_wr_data_q;
  assign frame_count  = frame_count_q;
  assign drop_count   = drop_count_q;
  assign trunc_count  = trunc_count_q;
endmodule
